// File: rtl/dice_pkg.sv
// Shared constants, state type and 7-segment encoder for the multi-die roller.
package dice_pkg;

    // Die sides per button channel, stored as 4-digit BCD.
    localparam logic [15:0] DIE_SIDES [0:7] = '{
        16'h0004, 16'h0006, 16'h0008, 16'h0010,
        16'h0012, 16'h0020, 16'h0100, 16'h0002
    };

    typedef enum logic {
        IDLE = 1'b0,
        ROLL = 1'b1
    } roll_state_e;

    // Segment order {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dice_debounce.sv
// One button channel: 2-flop synchroniser and tick-sampled run-length debouncer.
module dice_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic level
);

    logic [1:0] sync;
    logic [2:0] run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            run   <= 3'd0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tick) begin
                if (sync[1] == level) begin
                    run <= 3'd0;
                end else if (run == 3'(DEB_SAMPLES - 1)) begin
                    level <= ~level;
                    run   <= 3'd0;
                end else begin
                    run <= run + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/dice_roller_ndigit.sv
// Multi-die electronic dice: debounced buttons, bounded BCD roll counter and
// a scanned seven-segment display with leading-zero blanking.
module dice_roller_ndigit
    import dice_pkg::*;
#(
    parameter int NDIGITS     = 3,
    parameter int NBTN        = 8,
    parameter int PRESCALE    = 10,
    parameter int DEB_SAMPLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NBTN-1:0]      btn,
    input  logic                 seg_inv,
    input  logic                 dig_inv,
    output logic [7:0]           seg,
    output logic [NDIGITS-1:0]   dig_en,
    output logic [4*NDIGITS-1:0] result,
    output logic                 busy
);

    localparam int W  = 4 * NDIGITS;
    localparam int IW = $clog2(NDIGITS);

    if (NDIGITS < 2 || NDIGITS > 4) begin : g_bad_ndigits
        $error("NDIGITS must be 2..4");
    end
    if (NBTN < 1 || NBTN > 8) begin : g_bad_nbtn
        $error("NBTN must be 1..8");
    end
    if (DEB_SAMPLES < 2 || DEB_SAMPLES > 7) begin : g_bad_deb
        $error("DEB_SAMPLES must be 2..7");
    end
    for (genvar i = 0; i < NBTN; i++) begin : g_side_chk
        if ((DIE_SIDES[i] >> (4 * NDIGITS)) != 16'h0000) begin : g_too_wide
            $error("DIE_SIDES entry does not fit in NDIGITS digits");
        end
    end

    // Reset asserts asynchronously but releases two clocks later, on clk.
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    logic [PRESCALE-1:0] presc;
    logic                tick;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) presc <= '0;
        else            presc <= presc + 1'b1;
    end
    assign tick = (presc == '0);

    logic [NBTN-1:0] levels;
    logic            any;

    for (genvar i = 0; i < NBTN; i++) begin : g_deb
        dice_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_int_n),
            .raw   (btn[i]),
            .tick  (tick),
            .level (levels[i])
        );
    end
    assign any = |levels;

    logic [2:0] low_sel;
    always_comb begin
        low_sel = 3'd0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (levels[i]) low_sel = 3'(i);
        end
    end

    roll_state_e state, state_next;
    logic        load, step;
    logic [2:0]  sel;
    logic [W-1:0] value, value_dec, sides_new, sides_cur;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any)  state_next = ROLL;
            ROLL:    if (!any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ROLL);
        load = (state == IDLE) && any;
        step = (state == ROLL) && any;
    end

    assign sides_new = DIE_SIDES[low_sel][W-1:0];
    assign sides_cur = DIE_SIDES[sel][W-1:0];

    // BCD decrement: a zero digit becomes 9 and passes the borrow upward.
    always_comb begin
        logic borrow;
        borrow    = 1'b1;
        value_dec = value;
        for (int d = 0; d < NDIGITS; d++) begin
            if (borrow) begin
                if (value[4*d +: 4] == 4'd0) begin
                    value_dec[4*d +: 4] = 4'd9;
                end else begin
                    value_dec[4*d +: 4] = value[4*d +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sel   <= 3'd0;
            value <= W'(1);
        end else if (load) begin
            sel   <= low_sel;
            value <= sides_new;
        end else if (step) begin
            value <= (value == W'(1)) ? sides_cur : value_dec;
        end
    end
    assign result = value;

    // lit[i]: digit i is shown; upper digits go dark while they and all above are 0.
    logic [NDIGITS-1:0] lit;
    always_comb begin
        logic acc;
        acc = 1'b0;
        lit = '0;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            acc    = acc | (value[4*i +: 4] != 4'd0);
            lit[i] = acc;
        end
        lit[0] = 1'b1;
    end

    logic [IW-1:0]      idx;
    logic [7:0]         seg_reg;
    logic [NDIGITS-1:0] dig_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idx     <= '0;
            seg_reg <= 8'h00;
            dig_reg <= '0;
        end else begin
            idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + 1'b1;
            if (!busy && lit[idx]) begin
                seg_reg <= {1'b0, seg7(value[4*idx +: 4])};
                dig_reg <= NDIGITS'(1) << idx;
            end else begin
                seg_reg <= 8'h00;
                dig_reg <= '0;
            end
        end
    end

    assign seg    = seg_reg ^ {8{seg_inv}};
    assign dig_en = dig_reg ^ {NDIGITS{dig_inv}};

endmodule

// File: tb/tb_dice_roller_ndigit.sv
// Directed/randomised bench for dice_roller_ndigit with an arithmetic roll model.
module tb_dice_roller_ndigit;

    localparam int NDIGITS     = 3;
    localparam int NBTN        = 8;
    localparam int PRESCALE    = 4;
    localparam int DEB_SAMPLES = 3;
    localparam int TICK        = 1 << PRESCALE;
    localparam int LAT_MIN     = 2 + (DEB_SAMPLES - 1) * TICK;
    localparam int LAT_MAX     = 2 + DEB_SAMPLES * TICK + 2;
    localparam int WAIT_LIMIT  = LAT_MAX + 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NBTN-1:0]      btn = '0;
    logic                 seg_inv = 1'b0;
    logic                 dig_inv = 1'b0;
    logic [7:0]           seg;
    logic [NDIGITS-1:0]   dig_en;
    logic [4*NDIGITS-1:0] result;
    logic                 busy;

    dice_roller_ndigit #(
        .NDIGITS(NDIGITS), .NBTN(NBTN), .PRESCALE(PRESCALE), .DEB_SAMPLES(DEB_SAMPLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .seg_inv(seg_inv), .dig_inv(dig_inv),
        .seg(seg), .dig_en(dig_en), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         sides_tab [8] = '{4, 6, 8, 10, 12, 20, 100, 2};
    logic [6:0] seg_tab  [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference roll model state
    int   exp_val = 1;
    int   exp_sides = 4;
    int   roll_len = 0;
    int   roll_count = 0;
    int   cyc = 0;
    logic prev_busy = 1'b0;
    logic seen_borrow = 1'b0;
    logic [4*NDIGITS-1:0] prev_result = '0;

    function automatic int bcd2int(input logic [4*NDIGITS-1:0] b);
        int v;
        v = 0;
        for (int i = 0; i < NDIGITS; i++) v += int'(b[4*i +: 4]) * (10 ** i);
        return v;
    endfunction

    function automatic logic bcd_ok(input logic [4*NDIGITS-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from the observed busy level and compare result.
    task automatic step();
        int r;
        @(posedge clk);
        #1;
        cyc++;
        r = bcd2int(result);
        if (busy === 1'b1) begin
            if (!prev_busy) begin
                exp_val  = exp_sides;
                roll_len = 0;
                roll_count++;
            end else begin
                exp_val = (exp_val == 1) ? exp_sides : exp_val - 1;
            end
            roll_len++;
            check("roll_range", 32'((r >= 1) && (r <= exp_sides) && bcd_ok(result)), 32'd1);
        end
        if (prev_result == 12'h100 && result == 12'h099) seen_borrow = 1'b1;
        check("roll_value", 32'(r), 32'(exp_val));
        prev_busy   = busy;
        prev_result = result;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int k;
        k = 0;
        while (busy !== lvl && k < WAIT_LIMIT) begin
            step();
            k++;
        end
        check(tag, 32'(busy), 32'(lvl));
    endtask

    // Press channel ch for exactly hold clocks, then release and wait for idle.
    task automatic hold_roll(input int ch, input int hold);
        int t0;
        exp_sides = sides_tab[ch];
        btn[ch]   = 1'b1;
        t0        = cyc;
        wait_busy(1'b1, "busy_rise");
        check("busy_latency", 32'(((cyc - t0) >= LAT_MIN) && ((cyc - t0) <= LAT_MAX)), 32'd1);
        run(t0 + hold - cyc);
        btn[ch] = 1'b0;
        wait_busy(1'b0, "busy_fall");
        check("roll_len", 32'(roll_len), 32'(hold));
    endtask

    // Scan one full refresh and compare lit digits and their segments to v.
    task automatic disp_check(input int v);
        logic [NDIGITS-1:0] seen, dg, mask;
        logic [7:0]         sg;
        seen = '0;
        mask = '0;
        for (int i = 0; i < NDIGITS; i++) if (i == 0 || v >= 10 ** i) mask[i] = 1'b1;
        for (int k = 0; k < NDIGITS; k++) begin
            step();
            dg = dig_en ^ {NDIGITS{dig_inv}};
            sg = seg ^ {8{seg_inv}};
            check("disp_onehot", 32'($countones(dg) <= 1), 32'd1);
            for (int i = 0; i < NDIGITS; i++) begin
                if (dg[i]) begin
                    seen[i] = 1'b1;
                    check("disp_seg", 32'(sg), {24'd0, 1'b0, seg_tab[(v / (10 ** i)) % 10]});
                end
            end
        end
        check("disp_mask", 32'(seen), 32'(mask));
    endtask

    initial begin
        int rc0, t0, hold, ch;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'h001);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_dig", 32'(dig_en), 32'h0);
        rst_n = 1'b1;
        run(8);
        disp_check(1);
        disp_check(1);

        // d20 held for 112 clocks
        hold_roll(5, 112);
        check("d20_final", 32'(bcd2int(result)), 32'(20 - ((112 - 1) % 20)));
        run(4);
        disp_check(20 - ((112 - 1) % 20));

        // d100 across two wraps, including the 100 -> 099 borrow
        seen_borrow = 1'b0;
        hold_roll(6, 224);
        check("d100_final", 32'(bcd2int(result)), 32'(100 - ((224 - 1) % 100)));
        check("d100_borrow", 32'(seen_borrow), 32'd1);
        run(3);
        disp_check(100 - ((224 - 1) % 100));

        // Random die and hold length (multiple of tick period keeps roll length exact)
        for (int n = 0; n < 3; n++) begin
            ch   = $urandom_range(0, NBTN - 1);
            hold = TICK * $urandom_range(4, 12);
            hold_roll(ch, hold);
            check("rand_final", 32'(bcd2int(result)),
                  32'(sides_tab[ch] - ((hold - 1) % sides_tab[ch])));
            run($urandom_range(2, 9));
            disp_check(sides_tab[ch] - ((hold - 1) % sides_tab[ch]));
        end

        // d4 pressed, d12 added mid-roll: selection stays d4
        rc0       = roll_count;
        exp_sides = 4;
        btn[0]    = 1'b1;
        wait_busy(1'b1, "sel_busy_rise");
        btn[4] = 1'b1;
        run(40);
        btn[0] = 1'b0;
        run(60);
        check("sel_still_busy", 32'(busy), 32'd1);
        btn[4] = 1'b0;
        wait_busy(1'b0, "sel_busy_fall");
        check("sel_one_roll", 32'(roll_count), 32'(rc0 + 1));
        run(4);

        // Bounce on btn[1] each tick period never qualifies; the stable press rolls once
        rc0 = roll_count;
        exp_sides = 6;
        for (int k = 0; k < 8; k++) begin
            btn[1] = ~btn[1];
            run(TICK);
        end
        check("bounce_quiet", 32'(roll_count), 32'(rc0));
        hold_roll(1, 96);
        check("bounce_one_roll", 32'(roll_count), 32'(rc0 + 1));
        run(4);

        // Inverted polarity display of a two-digit result
        seg_inv = 1'b1;
        dig_inv = 1'b1;
        hold_roll(5, 48);
        check("inv_final", 32'(bcd2int(result)), 32'(20 - ((48 - 1) % 20)));
        run(3);
        disp_check(20 - ((48 - 1) % 20));
        check("inv_dig2_idle", 32'(dig_en[2]), 32'd1);

        // Reset in the middle of a roll
        exp_sides = 10;
        btn[3]    = 1'b1;
        wait_busy(1'b1, "mid_busy_rise");
        run(10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", 32'(result), 32'h001);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_seg", 32'(seg), 32'hFF);
        check("mid_rst_dig", 32'(dig_en), 32'h7);
        prev_busy = 1'b0;
        exp_val   = 1;
        run(3);
        rst_n = 1'b1;
        rc0   = roll_count;
        run(30);
        check("requalify_wait", 32'(roll_count), 32'(rc0));
        wait_busy(1'b1, "requalify_rise");
        run(20);
        btn[3] = 1'b0;
        wait_busy(1'b0, "requalify_fall");
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
